// File: rtl/mips_cp0.sv
// rtl/mips_cp0.sv - MIPS coprocessor 0: Status/Cause/EPC, exception and interrupt priority.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module mips_cp0 #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clock,
  input  logic               reset,
  output logic [63:0]        rd_data,
  output logic [63:0]        EPC,
  output logic               takenHandler,
  input  logic [63:0]        wr_data,
  input  logic [4:0]         regnum,
  input  logic [2:0]         sel,
  input  logic [63:0]        IF_pc,
  input  logic [63:0]        curr_pc,
  input  logic               MTC0,
  input  logic               ERET,
  input  logic [NUM_IRQ-1:0] interrupt_source,
  input  logic               overflow,
  input  logic               reserved_inst,
  input  logic               break_,
  input  logic               syscall
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic [4:0]  exc_code;
  logic [63:0] epc_q;
  logic [7:0]  irq_lines;
  logic [7:0]  cause_ip;
  logic        exc_req;
  logic        int_req;
  logic [4:0]  win_code;
  logic        wr_status;
  logic        wr_epc;

  always_comb begin
    irq_lines = '0;
    irq_lines[NUM_IRQ-1:0] = interrupt_source;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pending;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = MTC0 && (sel == 3'd0) && (regnum == 5'd9);
  assign wr_compare = MTC0 && (sel == 3'd0) && (regnum == 5'd11);
  assign cause_ip   = irq_lines | {timer_pending, 7'b0};

  // Pending stays set until software rewrites Compare.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      compare_q     <= '0;
      timer_pending <= 1'b0;
    end else begin
      count_q <= wr_count ? wr_data[31:0] : count_q + 32'd1;
      if (wr_compare) begin
        compare_q     <= wr_data[31:0];
        timer_pending <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pending <= 1'b1;
      end
    end
  end
`else
  assign cause_ip = irq_lines;
`endif

  assign exc_req      = reserved_inst | syscall | break_ | overflow;
  assign int_req      = status_ie && !status_exl && ((cause_ip & status_im) != 8'd0);
  assign takenHandler = reset && (exc_req || int_req);
  assign wr_status    = MTC0 && (sel == 3'd0) && (regnum == 5'd12);
  assign wr_epc       = MTC0 && (sel == 3'd0) && (regnum == 5'd14);
  assign EPC          = epc_q;

  always_comb begin
    win_code = 5'd0;
    if (reserved_inst)  win_code = 5'd10;
    else if (syscall)   win_code = 5'd8;
    else if (break_)    win_code = 5'd9;
    else if (overflow)  win_code = 5'd12;
  end

  // Exception updates are applied last so they override MTC0 and ERET on EXL/EPC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      exc_code   <= '0;
      epc_q      <= '0;
    end else begin
      if (wr_status) begin
        status_im  <= wr_data[15:8];
        status_exl <= wr_data[1];
        status_ie  <= wr_data[0];
      end
      if (ERET)
        status_exl <= 1'b0;
      if (wr_epc && !takenHandler)
        epc_q <= wr_data;
      if (takenHandler) begin
        exc_code   <= win_code;
        status_exl <= 1'b1;
        if (!status_exl)
          epc_q <= exc_req ? curr_pc : IF_pc;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel == 3'd0) begin
      case (regnum)
        5'd12: rd_data = {48'b0, status_im, 6'b0, status_exl, status_ie};
        5'd13: rd_data = {48'b0, cause_ip, 1'b0, exc_code, 2'b0};
        5'd14: rd_data = epc_q;
`ifdef CP0_TIMER_EN
        5'd9:  rd_data = {32'b0, count_q};
        5'd11: rd_data = {32'b0, compare_q};
`endif
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cp0.sv
// tb/tb_mips_cp0.sv - directed and randomized checks of mips_cp0 against a behavioural model.
module tb_mips_cp0;

  logic        clock;
  logic        reset;
  logic [63:0] rd_data;
  logic [63:0] EPC;
  logic        takenHandler;
  logic [63:0] wr_data;
  logic [4:0]  regnum;
  logic [2:0]  sel;
  logic [63:0] IF_pc;
  logic [63:0] curr_pc;
  logic        MTC0;
  logic        ERET;
  logic [7:0]  interrupt_source;
  logic        overflow;
  logic        reserved_inst;
  logic        break_;
  logic        syscall;

  int checks = 0;
  int failures = 0;

  mips_cp0 #(.NUM_IRQ(8)) dut (
    .clock(clock), .reset(reset), .rd_data(rd_data), .EPC(EPC),
    .takenHandler(takenHandler), .wr_data(wr_data), .regnum(regnum), .sel(sel),
    .IF_pc(IF_pc), .curr_pc(curr_pc), .MTC0(MTC0), .ERET(ERET),
    .interrupt_source(interrupt_source), .overflow(overflow),
    .reserved_inst(reserved_inst), .break_(break_), .syscall(syscall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Architectural state as software sees it.
  logic [7:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [4:0]  m_code;
  logic [63:0] m_epc;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_tp;

  task automatic m_reset();
    m_im = 0; m_ie = 0; m_exl = 0; m_code = 0; m_epc = 0;
    m_count = 0; m_compare = 0; m_tp = 0;
  endtask

  function automatic logic [7:0] m_ip();
    return interrupt_source | {m_tp, 7'b0};
  endfunction

  function automatic logic m_exc();
    return reserved_inst || syscall || break_ || overflow;
  endfunction

  function automatic logic m_take();
    return m_exc() || (m_ie && !m_exl && ((m_ip() & m_im) != 0));
  endfunction

  function automatic logic [4:0] m_winner();
    if (reserved_inst) return 10;
    if (syscall) return 8;
    if (break_) return 9;
    if (overflow) return 12;
    return 0;
  endfunction

  function automatic logic [63:0] m_read();
    if (sel != 0) return 0;
    case (regnum)
      12: return {48'b0, m_im, 6'b0, m_exl, m_ie};
      13: return {48'b0, m_ip(), 1'b0, m_code, 2'b0};
      14: return m_epc;
`ifdef CP0_TIMER_EN
      9:  return {32'b0, m_count};
      11: return {32'b0, m_compare};
`endif
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check combinational outputs, advance one edge, and apply the architectural rules to the model.
  task automatic tick();
    logic take, wr;
    logic [7:0] n_im; logic n_ie, n_exl; logic [4:0] n_code; logic [63:0] n_epc;
    logic [31:0] n_count, n_compare; logic n_tp;
    #1;
    chk("taken", {63'b0, takenHandler}, {63'b0, m_take()});
    chk("rd_data", rd_data, m_read());
    chk("epc_out", EPC, m_epc);
    take = m_take();
    wr = MTC0 && (sel == 0);
    n_im = m_im; n_ie = m_ie; n_exl = m_exl; n_code = m_code; n_epc = m_epc;
    if (wr && regnum == 12) begin n_im = wr_data[15:8]; n_ie = wr_data[0]; n_exl = wr_data[1]; end
    if (ERET) n_exl = 0;
    if (wr && regnum == 14) n_epc = wr_data;
    if (take) begin
      n_code = m_winner();
      n_exl = 1;
      n_epc = m_exl ? m_epc : (m_exc() ? curr_pc : IF_pc);
    end
    n_count = m_count + 1; n_compare = m_compare; n_tp = m_tp;
`ifdef CP0_TIMER_EN
    if (wr && regnum == 9) n_count = wr_data[31:0];
    if (m_count == m_compare) n_tp = 1;
    if (wr && regnum == 11) begin n_compare = wr_data[31:0]; n_tp = 0; end
`endif
    @(posedge clock);
    m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_code = n_code; m_epc = n_epc;
`ifdef CP0_TIMER_EN
    m_count = n_count; m_compare = n_compare; m_tp = n_tp;
`endif
    #1;
  endtask

  task automatic idle_inputs();
    MTC0 = 0; ERET = 0; overflow = 0; reserved_inst = 0; break_ = 0; syscall = 0;
    interrupt_source = 0; wr_data = 0; sel = 0;
  endtask

  initial begin
    bit seen;
    int sel_idx;
    logic [4:0] regs [6];
    reset = 0; idle_inputs(); regnum = 12; IF_pc = 0; curr_pc = 0;
    m_reset();
    #12;
    syscall = 1;
    #1;
    chk("reset_status", rd_data, 0);
    chk("reset_epc", EPC, 0);
    chk("reset_taken", {63'b0, takenHandler}, 0);
    syscall = 0;
    @(negedge clock); reset = 1;

    // Status write and readback
    MTC0 = 1; regnum = 12; wr_data = 64'h401; tick();
    MTC0 = 0; #1; chk("status_401", rd_data, 64'h401);
    regnum = 13; #1; chk("cause_idle", rd_data & 64'hFFFF_FFFF_FFFF_7FFF, 0);

    // SYSCALL with EXL clear
    curr_pc = 64'h0040_0010; syscall = 1; #1; chk("sys_taken", {63'b0, takenHandler}, 1);
    tick(); syscall = 0;
    #1; chk("sys_epc", EPC, 64'h0040_0010);
    regnum = 13; #1; chk("sys_code", {59'b0, rd_data[6:2]}, 8);
    regnum = 12; #1; chk("sys_exl", {63'b0, rd_data[1]}, 1);

    // Overflow with EXL set keeps EPC; ERET clears EXL
    curr_pc = 64'h0040_0020; overflow = 1; #1; chk("ovf_taken", {63'b0, takenHandler}, 1);
    tick(); overflow = 0;
    #1; chk("ovf_epc_held", EPC, 64'h0040_0010);
    regnum = 13; #1; chk("ovf_code", {59'b0, rd_data[6:2]}, 12);
    ERET = 1; tick(); ERET = 0;
    regnum = 12; #1; chk("eret_exl", {63'b0, rd_data[1]}, 0);

    // External interrupt on line 2
    interrupt_source = 8'h04; IF_pc = 64'h0040_0100; #1; chk("irq_taken", {63'b0, takenHandler}, 1);
    tick();
    #1; chk("irq_epc", EPC, 64'h0040_0100);
    chk("irq_masked_exl", {63'b0, takenHandler}, 0);
    regnum = 13; #1; chk("irq_code", {59'b0, rd_data[6:2]}, 0);
    chk("irq_ip", {57'b0, rd_data[14:8]}, 64'h04);
    MTC0 = 1; regnum = 12; wr_data = 64'h0001; tick(); MTC0 = 0;
    #1; chk("irq_masked_im", {63'b0, takenHandler}, 0);
    regnum = 13; #1; chk("irq_ip_masked", {57'b0, rd_data[14:8]}, 64'h04);
    tick();
    interrupt_source = 0;

    // Simultaneous exceptions plus an EPC write in the same cycle
    curr_pc = 64'h0040_0200; reserved_inst = 1; break_ = 1;
    MTC0 = 1; regnum = 14; wr_data = 64'hDEAD; tick();
    MTC0 = 0; reserved_inst = 0; break_ = 0;
    #1; chk("ri_epc", EPC, 64'h0040_0200);
    regnum = 13; #1; chk("ri_code", {59'b0, rd_data[6:2]}, 10);
    tick();

    // Asynchronous reset in the middle of a cycle
    regnum = 12; syscall = 1; #2;
    reset = 0; #1;
    chk("mid_reset_status", rd_data, 0);
    chk("mid_reset_epc", EPC, 0);
    chk("mid_reset_taken", {63'b0, takenHandler}, 0);
    regnum = 13; #1; chk("mid_reset_code", {59'b0, rd_data[6:2]}, 0);
    m_reset(); syscall = 0;
    @(negedge clock); reset = 1;

`ifdef CP0_TIMER_EN
    MTC0 = 1; regnum = 11; wr_data = 5; tick();
    regnum = 9; wr_data = 0; tick();
    regnum = 12; wr_data = 64'h8001; tick();
    MTC0 = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1; if (takenHandler) seen = 1;
      tick();
    end
    chk("timer_fired", {63'b0, seen}, 1);
    MTC0 = 1; regnum = 11; wr_data = 100; tick(); MTC0 = 0;
    regnum = 13; #1; chk("timer_cleared", {63'b0, rd_data[15]}, 0);
`endif

    // Randomized traffic against the model
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    for (int i = 0; i < 300; i++) begin
      sel_idx = $urandom_range(0, 5);
      regnum = (sel_idx == 5) ? 5'($urandom_range(0, 31)) : regs[sel_idx];
      sel = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      MTC0 = ($urandom_range(0, 3) == 0);
      wr_data = {$urandom, $urandom};
      ERET = ($urandom_range(0, 5) == 0);
      interrupt_source = 8'($urandom);
      reserved_inst = ($urandom_range(0, 9) == 0);
      syscall = ($urandom_range(0, 9) == 0);
      break_ = ($urandom_range(0, 9) == 0);
      overflow = ($urandom_range(0, 9) == 0);
      IF_pc = {$urandom, $urandom};
      curr_pc = {$urandom, $urandom};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
